// File: rtl/ones_comp_checksum.sv
// Ones'-complement checksum engine: folds a packet of W-bit words with end-around carry.
// Latency: fixed 2 edges from the accepted last word to out_valid; one word per cycle while accumulating.
// Backpressure: in_ready drops in FOLD/DONE; the result is held stable in DONE until out_ready.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   clear                    synchronous abort back to IDLE (highest priority)
//   in_valid/in_ready        input word handshake, with in_data and in_last
//   out_valid/out_ready      result handshake, with out_sum, out_check (= ~out_sum), out_count
module ones_comp_checksum #(
    parameter int W  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_sum,
    output logic [W-1:0]  out_check,
    output logic [CW-1:0] out_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        FOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic          carry_q, carry_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [W:0]    beat_sum;
    logic          accept;

    // Handshake outputs come from the registered state only, so no input
    // reaches an output combinationally.
    assign in_ready  = (state_q == IDLE) || (state_q == ACC);
    assign out_valid = (state_q == DONE);
    assign out_sum   = acc_q;
    assign out_check = ~acc_q;
    assign out_count = cnt_q;

    // The pending carry rides in as carry-in of the next word rather than
    // being folded immediately, keeping the per-beat path a single adder.
    assign beat_sum = {1'b0, acc_q} + {1'b0, in_data} + {{W{1'b0}}, carry_q};
    assign accept   = in_valid && in_ready && !clear;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;

        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            carry_d = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE, ACC: begin
                    if (accept) begin
                        acc_d   = beat_sum[W-1:0];
                        carry_d = beat_sum[W];
                        if (cnt_q != {CW{1'b1}}) begin
                            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                        end
                        state_d = in_last ? FOLD : ACC;
                    end
                end
                FOLD: begin
                    // acc can never be all-ones while carry is pending, so
                    // this final fold cannot itself overflow.
                    acc_d   = acc_q + {{(W-1){1'b0}}, carry_q};
                    carry_d = 1'b0;
                    state_d = DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        carry_d = 1'b0;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/ones_comp_checksum.md
# ones_comp_checksum

Sequential ones'-complement checksum engine. It accepts a stream of W-bit words over a valid/ready handshake and folds each word into an accumulator with end-around carry. On the last word it folds the pending carry and presents both the sum and its complement, the checksum, on an output handshake. It sits in front of the ones'-complement adder datapath and sequences repeated additions over a packet, rather than over a single operand pair.

## Interface
- W, 4, data word width in bits (W ≥ 2)
- CW, 8, beat-counter width in bits

- clk  input  1  rising-edge clock, the only clock
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous abort; returns the block to IDLE
- in_valid  input  1  in_data and in_last are valid
- in_ready  output  1  block can accept a word
- in_data  input  W  word to add
- in_last  input  1  marks the final word of a packet
- out_valid  output  1  result available
- out_ready  input  1  consumer takes the result
- out_sum  output  W  ones'-complement sum
- out_check  output  W  checksum, equal to ~out_sum
- out_count  output  CW  words accepted in this packet, saturating

## Operation
- Registers:
  - acc[W-1:0]
  - carry (pending end-around carry)
  - cnt[CW-1:0]
  - state ∈ {IDLE, ACC, FOLD, DONE}
- Beat accept: occurs on a rising edge where in_valid & in_ready & !clear.
  - {carry, acc} <= acc + in_data + carry, computed in W+1 bits. The pending carry enters as carry-in of the next addition.
  - cnt <= cnt + 1, saturating at 2^CW−1.
- IDLE:
  - in_ready=1.
  - Accept with !in_last → ACC.
  - Accept with in_last → FOLD.
- ACC:
  - in_ready=1.
  - Accept with in_last → FOLD; otherwise stay in ACC.
  - No in_valid → hold all state, with no timeout.
- FOLD:
  - in_ready=0.
  - On the next edge: acc <= acc + carry, carry <= 0, → DONE.
  - Invariant: acc ≤ 2^W−2 whenever carry=1, so the fold never overflows. The bench asserts this.
- DONE:
  - out_valid=1, out_sum=acc, out_check=~acc, out_count=cnt.
  - in_ready=0.
  - Outputs stay stable while out_ready=0.
  - On out_valid & out_ready → IDLE, and acc, carry and cnt clear to 0.
- Negative zero (all ones) is not normalized: out_sum=all-ones gives out_check=0.
- clear has highest priority in every state. Next state is IDLE and acc, carry and cnt clear to 0.
  - A beat presented in the same cycle is dropped.
  - A result held in DONE is discarded.
- rst_n low at any time, including mid-packet or in DONE, forces the same cleared state immediately and asynchronously.

## Timing
- Reset values:
  - state=IDLE
  - in_ready=1
  - out_valid=0
  - out_sum=0
  - out_check=all-ones (~0)
  - out_count=0
- in_ready and out_valid are decoded from registered state only. There is no combinational path from any input to any output.
- Throughput: one word per cycle in IDLE and ACC.
- Latency: a last word accepted at edge k gives FOLD during cycle k→k+1 and out_valid high after edge k+1. That is a fixed 2 edges from acceptance to result visible, independent of the data.
- Minimum packet period: N words take N + 2 cycles when out_ready is held high. A new packet may start on the edge after the out_ready handshake.
- A single-word packet goes IDLE → FOLD directly, with the same 2-edge latency.

## Test plan
- W=4, send 0x5 then 0x6 (last) with out_ready=1 → out_valid two edges after the last accept; out_sum=0xB, out_check=0x4, out_count=2.
- Send 0x9 then 0x8 (last) → carry is folded; out_sum=0x2, out_check=0xD, out_count=2.
- Send 0xF, 0xF, 0xF (last) with the last beat accepted while carry is pending → out_sum=0xF, out_check=0x0 (negative zero kept); the fold-overflow assertion never fires.
- Single word 0x0 (last) with out_ready held 0 for 5 cycles → in_ready=0 and out_sum=0x0, out_check=0xF stable throughout; IDLE and in_ready=1 one edge after out_ready rises.
- Send 0x3, 0x4, then assert clear with in_valid=1 and data 0x7 → the 0x7 beat is dropped; the next packet 0x1 (last) yields out_sum=0x1, out_count=1.
- Drop rst_n mid-packet after 0xA, then again while in DONE → in_ready=1, out_valid=0 and out_count=0 immediately, without waiting for a clock edge; a subsequent packet 0x2, 0x3 (last) gives out_sum=0x5.
